// File: rtl/slave_arb_pkg.sv
// Shared types and default sizing for the slave channel arbiter.
package slave_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned DATA_W    = 4;
   localparam int unsigned MAX_BURST = 10;

endpackage

// File: rtl/slave_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request after the last winner.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx
);

   int unsigned w_j;
   logic        w_found;

   // Offsets 1..NUM_REQ so the previous winner is examined last.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      w_j      = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_j = (int'(i_last) + k) % NUM_REQ;
         if (!w_found && i_req[IDX_W'(w_j)]) begin
            w_found                 = 1'b1;
            o_idx                   = IDX_W'(w_j);
            o_onehot[IDX_W'(w_j)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/slave_arb.sv
// Round-robin arbiter granting one requester a burst of up to MAX_BURST beats on a shared slave.
module slave_arb #(
   parameter int unsigned NUM_REQ   = slave_arb_pkg::NUM_REQ,
   parameter int unsigned DATA_W    = slave_arb_pkg::DATA_W,
   parameter int unsigned MAX_BURST = slave_arb_pkg::MAX_BURST
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]          req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               m_valid,
   output logic [DATA_W-1:0]                  m_data,
   input  logic                               m_ready,
   output logic [NUM_REQ-1:0]                 grant,
   output logic [$clog2(MAX_BURST+1)-1:0]     beat_cnt
);

   import slave_arb_pkg::*;

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   state_t             r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_win;
   logic [IDX_W-1:0]   r_gidx, w_gidx_nxt, r_last, w_last_nxt, w_win_idx;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_gvalid, w_beat;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req    (req_valid),
      .i_last   (r_last),
      .o_onehot (w_win),
      .o_idx    (w_win_idx)
   );

   // Outputs are forced low while rst is high so no beat can complete in a reset cycle.
   always_comb begin
      w_gvalid  = req_valid[r_gidx];
      m_valid   = 1'b0;
      m_data    = '0;
      req_ready = '0;
      if (r_state == BUSY && !rst) begin
         m_valid   = w_gvalid;
         m_data    = req_data[r_gidx*DATA_W +: DATA_W];
         req_ready = r_grant & {NUM_REQ{m_ready}};
      end
      w_beat = m_valid && m_ready;
   end

   assign grant    = rst ? '0 : r_grant;
   assign beat_cnt = rst ? '0 : r_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_win;
               w_gidx_nxt  = w_win_idx;
               w_cnt_nxt   = '0;
            end
         end
         BUSY: begin
            if (!w_gvalid || (w_beat && r_cnt == CNT_W'(MAX_BURST - 1))) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_cnt_nxt   = '0;
               w_last_nxt  = r_gidx;
            end else if (w_beat) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gidx  <= w_gidx_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_slave_arb.sv
// Randomized and directed bench for slave_arb against an integer-level arbitration model.
module tb_slave_arb;

   localparam int NR  = 4;
   localparam int DW  = 4;
   localparam int MB  = 10;
   localparam int CW  = $clog2(MB + 1);
   localparam int DAW = NR * DW;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req_valid, req_ready, grant;
   logic [DAW-1:0] req_data;
   logic           m_valid, m_ready;
   logic [DW-1:0]  m_data;
   logic [CW-1:0]  beat_cnt;

   int n_checks = 0;
   int n_errs   = 0;

   // Model state: busy flag, granted index, beats taken, last granted index.
   int md_busy, md_g, md_cnt, md_last;

   logic [NR-1:0] ob_grant;
   int            ob_cnt;
   logic          ob_beat;

   always #5 clk = ~clk;

   slave_arb #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .grant     (grant),
      .beat_cnt  (beat_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check outputs against the model, then advance the model.
   task automatic step(input logic r, input logic [NR-1:0] v, input logic mr);
      logic [NR-1:0] e_grant, e_ready;
      logic          e_mv;
      logic [DW-1:0] e_md;
      int            e_cnt;
      logic          found;
      @(negedge clk);
      rst       = r;
      req_valid = v;
      m_ready   = mr;
      req_data  = DAW'($urandom);
      #1;
      e_grant = '0;
      e_ready = '0;
      e_mv    = 1'b0;
      e_md    = '0;
      e_cnt   = r ? 0 : md_cnt;
      if (!r && md_busy != 0) begin
         e_grant[md_g] = 1'b1;
         e_mv          = v[md_g];
         e_md          = req_data[md_g*DW +: DW];
         if (mr) e_ready[md_g] = 1'b1;
      end
      check_eq("grant", grant, e_grant);
      check_eq("m_valid", m_valid, e_mv);
      check_eq("m_data", m_data, e_md);
      check_eq("req_ready", req_ready, e_ready);
      check_eq("beat_cnt", beat_cnt, e_cnt);
      check_eq("isolation", req_ready & ~grant, 0);
      check_eq("onehot", $countones(grant) > 1, 0);
      ob_grant = grant;
      ob_cnt   = beat_cnt;
      ob_beat  = m_valid && m_ready;
      if (r) begin
         md_busy = 0;
         md_cnt  = 0;
         md_last = NR - 1;
      end else if (md_busy == 0) begin
         if (v != 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
               if (!found && v[(md_last + k) % NR]) begin
                  found = 1'b1;
                  md_g  = (md_last + k) % NR;
               end
            end
            md_busy = 1;
            md_cnt  = 0;
         end
      end else if (!v[md_g]) begin
         md_busy = 0;
         md_last = md_g;
         md_cnt  = 0;
      end else if (mr) begin
         md_cnt++;
         if (md_cnt == MB) begin
            md_busy = 0;
            md_last = md_g;
            md_cnt  = 0;
         end
      end
   endtask

   initial begin
      logic [NR-1:0] seq_q[$];
      logic [NR-1:0] exp_seq [5];
      logic [NR-1:0] prev, rv;
      int            beats;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1; req_valid = '0; req_data = '0; m_ready = 1'b0;
      md_busy = 0; md_g = 0; md_cnt = 0; md_last = NR - 1;

      // Single requester: 10 beats, one idle cycle, regranted.
      repeat (3) step(1'b1, '0, 1'b0);
      step(1'b0, 4'b0001, 1'b1);
      check_eq("single_first_idle", ob_grant, 0);
      beats = 0;
      repeat (10) begin
         step(1'b0, 4'b0001, 1'b1);
         if (ob_beat) beats++;
      end
      check_eq("single_beats", beats, 10);
      step(1'b0, 4'b0001, 1'b1);
      check_eq("single_gap", ob_grant, 0);
      step(1'b0, 4'b0001, 1'b1);
      check_eq("single_regrant", ob_grant, 4'b0001);

      // Full contention: rotating grant sequence.
      repeat (2) step(1'b1, '0, 1'b0);
      prev = '0;
      repeat (60) begin
         step(1'b0, 4'b1111, 1'b1);
         if (ob_grant != 0 && prev == 0) seq_q.push_back(ob_grant);
         prev = ob_grant;
      end
      check_eq("rr_count", seq_q.size() >= 5, 1);
      for (int i = 0; i < 5; i++) begin
         if (i < seq_q.size()) check_eq("rr_seq", seq_q[i], exp_seq[i]);
      end

      // Early release by requester 1 after 3 beats.
      repeat (2) step(1'b1, '0, 1'b0);
      step(1'b0, 4'b1110, 1'b1);
      repeat (3) step(1'b0, 4'b1110, 1'b1);
      check_eq("early_grant", ob_grant, 4'b0010);
      step(1'b0, 4'b1100, 1'b1);
      check_eq("early_cnt", ob_cnt, 3);
      step(1'b0, 4'b1100, 1'b1);
      check_eq("early_idle", ob_grant, 0);
      step(1'b0, 4'b1100, 1'b1);
      check_eq("early_next", ob_grant, 4'b0100);

      // Backpressure: 7 stalled cycles mid-burst.
      repeat (2) step(1'b1, '0, 1'b0);
      step(1'b0, 4'b0001, 1'b1);
      beats = 0;
      repeat (3) begin
         step(1'b0, 4'b0001, 1'b1);
         if (ob_beat) beats++;
      end
      repeat (7) begin
         step(1'b0, 4'b0001, 1'b0);
         if (ob_beat) beats++;
         check_eq("bp_hold_cnt", ob_cnt, 3);
         check_eq("bp_hold_grant", ob_grant, 4'b0001);
      end
      repeat (7) begin
         step(1'b0, 4'b0001, 1'b1);
         if (ob_beat) beats++;
      end
      check_eq("bp_beats", beats, 10);
      step(1'b0, 4'b0001, 1'b1);
      check_eq("bp_release", ob_grant, 0);

      // Reset pulsed at beat 5.
      repeat (2) step(1'b1, '0, 1'b0);
      step(1'b0, 4'b0100, 1'b1);
      repeat (5) step(1'b0, 4'b1111, 1'b1);
      step(1'b1, 4'b1111, 1'b1);
      check_eq("rst_mid_grant", ob_grant, 0);
      check_eq("rst_mid_beat", ob_beat, 0);
      step(1'b0, 4'b1111, 1'b1);
      step(1'b0, 4'b1111, 1'b1);
      check_eq("rst_first_winner", ob_grant, 4'b0001);

      // Random traffic with sticky valids, backpressure and rare resets.
      rv = 4'b1111;
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) rv = NR'($urandom);
         step($urandom_range(0, 199) == 0, rv, $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
